// File: rtl/diaosi_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : diaosi_types_pkg
// Brief    : Shared fetch-path types: PC source kinds, BTB entry layout and
//            the 2-bit saturating counter step helper.
// Revision : 1.0 - initial BTB-based fetch predictor types
// ============================================================================
package diaosi_types_pkg;

   typedef logic [31:0] word_t;

   // Kind of control instruction being resolved in decode.
   typedef enum logic [1:0] {
      PC_SEQ = 2'd0,
      PC_BR  = 2'd1,
      PC_J   = 2'd2,
      PC_JR  = 2'd3
   } PCSrc_t;

   // Widest tag the BTB can need (IDX_W >= 1); narrower tags are stored
   // zero-extended so the entry layout is independent of BTB depth.
   localparam int c_tag_max_w = 29;

   typedef struct packed {
      logic                   valid;
      logic [c_tag_max_w-1:0] tag;
      word_t                  target;
      logic [1:0]             ctr;
   } btb_entry_t;

   // One step of a 2-bit saturating counter towards taken (up) or not taken.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
      if (up) begin
         return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
      end
      return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btb_dm.sv
`default_nettype none
// ============================================================================
// Module   : btb_dm
// Brief    : Direct-mapped branch target buffer. Combinational lookup port,
//            single update port with counter training / allocation, and
//            asynchronous clear of the valid bits.
// Revision : 1.0 - initial implementation
// ============================================================================
module btb_dm
   import diaosi_types_pkg::*;
#(
   parameter int BTB_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   // lookup port (word address, i.e. byte address [31:2])
   input  logic [29:0] i_lookup_waddr,
   output logic        o_pred_taken,
   output word_t       o_pred_target,
   // update port
   input  logic        i_upd_en,
   input  logic [29:0] i_upd_waddr,
   input  PCSrc_t      i_upd_kind,
   input  logic        i_upd_taken,
   input  word_t       i_upd_target
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic [BTB_ENTRIES-1:0] r_valid;
   logic [c_tag_max_w-1:0] r_tag    [BTB_ENTRIES];
   word_t                  r_target [BTB_ENTRIES];
   logic [1:0]             r_ctr    [BTB_ENTRIES];

   logic [IDX_W-1:0]       w_lk_idx;
   logic [c_tag_max_w-1:0] w_lk_tag;
   logic                   w_lk_hit;
   logic [IDX_W-1:0]       w_up_idx;
   logic [c_tag_max_w-1:0] w_up_tag;
   logic                   w_up_hit;
   logic                   w_wr_en;
   btb_entry_t             w_wr;

   assign w_lk_idx = i_lookup_waddr[IDX_W-1:0];
   assign w_lk_tag = c_tag_max_w'(i_lookup_waddr[29:IDX_W]);
   assign w_up_idx = i_upd_waddr[IDX_W-1:0];
   assign w_up_tag = c_tag_max_w'(i_upd_waddr[29:IDX_W]);

   // Lookup reads the current (pre-write) contents, so a same-cycle update
   // of the same index only becomes visible on the following cycle.
   always_comb begin
      w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
      o_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
      o_pred_target = r_target[w_lk_idx];
   end

   // Decide whether the resolving control instruction trains or allocates.
   always_comb begin
      w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
      w_wr_en    = 1'b0;
      w_wr.valid = 1'b1;
      w_wr.tag   = w_up_tag;
      w_wr.target = i_upd_target;
      w_wr.ctr   = r_ctr[w_up_idx];
      if (i_upd_en && (i_upd_kind != PC_SEQ)) begin
         if (w_up_hit) begin
            w_wr_en  = 1'b1;
            w_wr.ctr = (i_upd_kind == PC_BR) ? ctr_step(r_ctr[w_up_idx], i_upd_taken)
                                             : 2'd3;
         end else if (i_upd_taken) begin
            // Branches start weakly taken, unconditional jumps strongly taken.
            w_wr_en  = 1'b1;
            w_wr.ctr = (i_upd_kind == PC_BR) ? 2'd2 : 2'd3;
         end
      end
   end

   // Valid bits are the only BTB state cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
      end else if (w_wr_en) begin
         r_valid[w_up_idx] <= w_wr.valid;
      end
   end

   // Tag/target/counter payload; no reset, masked by valid until written.
   always_ff @(posedge clk) begin
      if (w_wr_en && !rst) begin
         r_tag[w_up_idx]    <= w_wr.tag;
         r_target[w_up_idx] <= w_wr.target;
         r_ctr[w_up_idx]    <= w_wr.ctr;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_predict_unit
// Brief    : Fetch-address generator. PC register with BTB-driven next-PC
//            prediction, decode-stage branch/jump resolution, mispredict
//            redirect and saturating control/mispredict statistics.
// Revision : 1.0 - initial implementation, successor of the plain PC
// ============================================================================
module pc_predict_unit
   import diaosi_types_pkg::*;
#(
   parameter word_t PC_RESET    = 32'h0000_0000,
   parameter int    BTB_ENTRIES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        pc_en,
   output word_t       i_addr,
   output logic        pred_taken,
   output word_t       pred_target,
   input  logic        res_valid,
   input  word_t       res_pc,
   input  PCSrc_t      PCSrc,
   input  logic [15:0] imm16,
   input  logic [25:0] j_addr26,
   input  word_t       jr,
   input  logic        br_cond,
   input  logic        res_pred_taken,
   input  word_t       res_pred_target,
   output logic        redirect,
   output word_t       ctl_count,
   output word_t       mis_count
);

   word_t r_pc;
   word_t r_ctl_count;
   word_t r_mis_count;

   word_t w_pc4;
   word_t w_br_target;
   word_t w_target;
   word_t w_correct;
   logic  w_taken;
   logic  w_mispredict;
   logic  w_ctl_event;
   logic  w_btb_taken;
   word_t w_btb_target;

   btb_dm #(
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk            (CLK),
      .rst            (RST),
      .i_lookup_waddr (r_pc[31:2]),
      .o_pred_taken   (w_btb_taken),
      .o_pred_target  (w_btb_target),
      .i_upd_en       (res_valid),
      .i_upd_waddr    (res_pc[31:2]),
      .i_upd_kind     (PCSrc),
      .i_upd_taken    (w_taken),
      .i_upd_target   (w_target)
   );

   // Actual outcome of the resolving instruction and mispredict detection.
   always_comb begin
      w_pc4       = res_pc + 32'd4;
      w_br_target = w_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
      w_taken     = 1'b0;
      w_target    = w_pc4;
      case (PCSrc)
         PC_SEQ: begin
            w_taken  = 1'b0;
            w_target = w_pc4;
         end
         PC_BR: begin
            w_taken  = br_cond;
            w_target = w_br_target;
         end
         PC_J: begin
            w_taken  = 1'b1;
            w_target = {w_pc4[31:28], j_addr26, 2'b00};
         end
         PC_JR: begin
            w_taken  = 1'b1;
            w_target = jr;
         end
         default: begin
            w_taken  = 1'b0;
            w_target = w_pc4;
         end
      endcase
      // A stale BTB hit on a non-branch (PC_SEQ) is also caught here.
      w_mispredict = res_valid &&
                     ((w_taken != res_pred_taken) ||
                      (w_taken && (w_target != res_pred_target)));
      w_correct    = w_taken ? w_target : w_pc4;
      w_ctl_event  = res_valid && (PCSrc != PC_SEQ);
   end

   // Prediction for the current fetch address.
   always_comb begin
      pred_taken  = w_btb_taken;
      pred_target = w_btb_taken ? w_btb_target : r_pc + 32'd4;
   end

   // PC register: redirect overrides a stall, otherwise follow the prediction.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pc <= PC_RESET;
      end else if (w_mispredict) begin
         r_pc <= w_correct;
      end else if (pc_en) begin
         r_pc <= pred_target;
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ctl_count <= '0;
         r_mis_count <= '0;
      end else begin
         if (w_ctl_event && (r_ctl_count != 32'hFFFF_FFFF)) begin
            r_ctl_count <= r_ctl_count + 32'd1;
         end
         if (w_mispredict && (r_mis_count != 32'hFFFF_FFFF)) begin
            r_mis_count <= r_mis_count + 32'd1;
         end
      end
   end

   assign i_addr    = r_pc;
   assign redirect  = w_mispredict;
   assign ctl_count = r_ctl_count;
   assign mis_count = r_mis_count;

endmodule
`default_nettype wire
